// File: rtl/aes_block_feeder.sv
// AES stimulus feeder: streams LFSR plaintext blocks plus a fixed key over valid/ready.
// Counts and XOR-folds ciphertexts; optional stall watchdog under `AES_FEED_TIMEOUT_EN`.
module aes_block_feeder #(
  parameter int unsigned  NUM_BLOCKS  = 16,
  parameter logic [127:0] SEED        = 128'h1,
  parameter logic [127:0] KEY         = 128'h000102030405060708090a0b0c0d0e0f,
  parameter int unsigned  TIMEOUT_CYC = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [127:0] pt_data,
  output logic [127:0] key_data,
  output logic         in_valid,
  input  logic         in_ready,
  input  logic         out_valid,
  input  logic [127:0] ct_data,
  output logic         busy,
  output logic         done,
  output logic [15:0]  sent_cnt,
  output logic [15:0]  recv_cnt,
  output logic [127:0] sig,
  output logic         ovf_err,
  output logic         timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] NB = 16'(NUM_BLOCKS);

  state_t       r_state;
  logic [127:0] r_lfsr;
  logic [127:0] r_sig;
  logic [15:0]  r_sent_cnt;
  logic [15:0]  r_recv_cnt;
  logic         r_in_valid;
  logic         r_busy;
  logic         r_done;
  logic         r_ovf_err;

  logic         w_restart;
  logic         w_accept;
  logic         w_resp;
  logic         w_recv_inc;
  logic         w_timeout;
  logic [15:0]  w_recv_next;
  logic [15:0]  w_sent_next;
  logic [127:0] w_lfsr_next;

  // Multiply by x in GF(2^128), reduction polynomial x^128 + x^7 + x^2 + x + 1.
  function automatic logic [127:0] gf_double(input logic [127:0] v);
    return {v[126:0], 1'b0} ^ (v[127] ? 128'h87 : 128'h0);
  endfunction

  assign w_restart   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_accept    = (r_state == SEND) && r_in_valid && in_ready;
  assign w_resp      = out_valid && (r_state != IDLE);
  assign w_recv_inc  = w_resp && (r_recv_cnt < NB);
  assign w_recv_next = r_recv_cnt + {15'd0, w_recv_inc};
  assign w_sent_next = r_sent_cnt + 16'd1;
  assign w_lfsr_next = gf_double(r_lfsr);

  // Run control, plaintext generation and response folding; restart wins over a same-cycle response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_lfsr     <= SEED;
      r_sig      <= 128'h0;
      r_sent_cnt <= 16'd0;
      r_recv_cnt <= 16'd0;
      r_in_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf_err  <= 1'b0;
    end else if (w_restart) begin
      r_lfsr     <= SEED;
      r_sig      <= 128'h0;
      r_sent_cnt <= 16'd0;
      r_recv_cnt <= 16'd0;
      r_ovf_err  <= 1'b0;
      if (NB == 16'd0) begin
        r_state    <= DONE;
        r_in_valid <= 1'b0;
        r_busy     <= 1'b0;
        r_done     <= 1'b1;
      end else begin
        r_state    <= SEND;
        r_in_valid <= 1'b1;
        r_busy     <= 1'b1;
        r_done     <= 1'b0;
      end
    end else begin
      if (w_resp) begin
        if (w_recv_inc) begin
          r_recv_cnt <= w_recv_next;
          r_sig      <= r_sig ^ ct_data;
        end else begin
          r_ovf_err  <= 1'b1;
        end
      end
      case (r_state)
        SEND: begin
          if (w_timeout) begin
            r_state    <= DONE;
            r_in_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end else if (w_accept) begin
            r_sent_cnt <= w_sent_next;
            r_lfsr     <= w_lfsr_next;
            if (w_sent_next == NB) begin
              r_state    <= DRAIN;
              r_in_valid <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Completion counts a response arriving in this very cycle.
          if (w_timeout || (w_recv_next == NB)) begin
            r_state    <= DONE;
            r_in_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

`ifdef AES_FEED_TIMEOUT_EN
  localparam logic [15:0] TO = 16'(TIMEOUT_CYC);

  logic [15:0] r_stall;
  logic        r_timeout_err;
  logic        w_stalled;

  assign w_stalled = ((r_state == SEND) && !in_ready) || ((r_state == DRAIN) && !out_valid);
  assign w_timeout = w_stalled && ((r_stall + 16'd1) == TO);

  // Stall watchdog; any progress or leaving SEND/DRAIN clears the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall       <= 16'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_stall <= w_stalled ? (r_stall + 16'd1) : 16'd0;
      if (w_restart) begin
        r_timeout_err <= 1'b0;
      end else if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign pt_data  = r_lfsr;
  assign key_data = KEY;
  assign in_valid = r_in_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign sent_cnt = r_sent_cnt;
  assign recv_cnt = r_recv_cnt;
  assign sig      = r_sig;
  assign ovf_err  = r_ovf_err;

endmodule

// File: tb/tb_aes_block_feeder.sv
// Self-checking bench for aes_block_feeder: randomized core behaviour against a queue-based model.
module tb_aes_block_feeder;
  localparam logic [127:0] SEED_A = 128'h1;
  localparam logic [127:0] SEED_W = {1'b1, 127'd0};
  localparam logic [127:0] KEY_V  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam int NB_A = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic         start = 1'b0, in_ready = 1'b0, out_valid = 1'b0;
  logic [127:0] ct_data = 128'h0;
  logic [127:0] pt_data, key_data, sig;
  logic         in_valid, busy, done, ovf_err, timeout_err;
  logic [15:0]  sent_cnt, recv_cnt;

  logic         w_start = 1'b0, w_in_ready = 1'b0, w_out_valid = 1'b0;
  logic [127:0] w_ct_data = 128'h0;
  logic [127:0] w_pt_data, w_key_data, w_sig;
  logic         w_in_valid, w_busy, w_done, w_ovf_err, w_timeout_err;
  logic [15:0]  w_sent_cnt, w_recv_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  aes_block_feeder #(.NUM_BLOCKS(NB_A), .SEED(SEED_A), .KEY(KEY_V), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .start(start), .pt_data(pt_data), .key_data(key_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .ct_data(ct_data),
    .busy(busy), .done(done), .sent_cnt(sent_cnt), .recv_cnt(recv_cnt), .sig(sig),
    .ovf_err(ovf_err), .timeout_err(timeout_err));

  aes_block_feeder #(.NUM_BLOCKS(2), .SEED(SEED_W), .KEY(KEY_V), .TIMEOUT_CYC(8)) dut_w (
    .clk(clk), .rst(rst), .start(w_start), .pt_data(w_pt_data), .key_data(w_key_data),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .out_valid(w_out_valid), .ct_data(w_ct_data),
    .busy(w_busy), .done(w_done), .sent_cnt(w_sent_cnt), .recv_cnt(w_recv_cnt), .sig(w_sig),
    .ovf_err(w_ovf_err), .timeout_err(w_timeout_err));

  // Polynomial view: multiply by x, subtract the field polynomial when degree reaches 128.
  function automatic logic [127:0] mul_x(input logic [127:0] v);
    logic [128:0] p;
    p = {v, 1'b0};
    if (p[128]) p = p ^ {1'b1, 120'd0, 8'h87};
    return p[127:0];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (in_valid !== 1'b0) $display("FAIL rst_in_valid got %0b exp 0", in_valid); else n_pass++;
    n_checks++; if ({busy, done, ovf_err, timeout_err} !== 4'b0) $display("FAIL rst_flags got %b exp 0000", {busy, done, ovf_err, timeout_err}); else n_pass++;
    n_checks++; if ({sent_cnt, recv_cnt} !== 32'd0) $display("FAIL rst_counts got %0d/%0d exp 0/0", sent_cnt, recv_cnt); else n_pass++;
    n_checks++; if (sig !== 128'h0) $display("FAIL rst_sig got %h exp 0", sig); else n_pass++;
    n_checks++; if (pt_data !== SEED_A) $display("FAIL rst_pt got %h exp %h", pt_data, SEED_A); else n_pass++;
    n_checks++; if (key_data !== KEY_V || w_key_data !== KEY_V) $display("FAIL rst_key got %h exp %h", key_data, KEY_V); else n_pass++;
    n_checks++; if (w_pt_data !== SEED_W || w_in_valid !== 1'b0 || w_timeout_err !== 1'b0) $display("FAIL rst_w got pt=%h iv=%b exp pt=%h iv=0", w_pt_data, w_in_valid, SEED_W); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    out_valid = 1'b1; ct_data = rand128();
    @(posedge clk); #1;
    out_valid = 1'b0;
    n_checks++; if (recv_cnt !== 16'd0 || sig !== 128'h0 || ovf_err !== 1'b0) $display("FAIL idle_resp got recv=%0d ovf=%b exp recv=0 ovf=0", recv_cnt, ovf_err); else n_pass++;
  endtask

  task automatic test_wrap();
    w_start = 1'b1; w_in_ready = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    n_checks++; if (w_pt_data !== SEED_W || w_in_valid !== 1'b1) $display("FAIL wrap_first got pt=%h iv=%b exp pt=%h iv=1", w_pt_data, w_in_valid, SEED_W); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (w_pt_data !== 128'h87 || w_sent_cnt !== 16'd1) $display("FAIL wrap_second got pt=%h sent=%0d exp pt=87 sent=1", w_pt_data, w_sent_cnt); else n_pass++;
    w_out_valid = 1'b1; w_ct_data = SEED_W;
    @(posedge clk); #1;
    n_checks++; if (w_sent_cnt !== 16'd2 || w_recv_cnt !== 16'd1 || w_in_valid !== 1'b0 || w_done !== 1'b0) $display("FAIL wrap_drain got sent=%0d recv=%0d iv=%b done=%b exp 2 1 0 0", w_sent_cnt, w_recv_cnt, w_in_valid, w_done); else n_pass++;
    w_ct_data = 128'h87; w_in_ready = 1'b0;
    @(posedge clk); #1;
    w_out_valid = 1'b0;
    n_checks++; if (w_recv_cnt !== 16'd2 || w_done !== 1'b1 || w_busy !== 1'b0 || w_ovf_err !== 1'b0) $display("FAIL wrap_done got recv=%0d done=%b busy=%b exp 2 1 0", w_recv_cnt, w_done, w_busy); else n_pass++;
    n_checks++; if (w_sig !== (SEED_W ^ 128'h87)) $display("FAIL wrap_sig got %h exp %h", w_sig, SEED_W ^ 128'h87); else n_pass++;
  endtask

  // mode 0: always ready, 1-cycle loopback; mode 1: 3-cycle stall on pt=2; mode 2: random everything.
  task automatic test_stream(input int mode);
    logic [127:0] exp_pt, msig;
    logic [127:0] resp_q[$];
    int msent, mrecv, stall_left, cyc;
    bit stalled_once, was_stall, acc;
    exp_pt = SEED_A; msig = 128'h0; msent = 0; mrecv = 0; stall_left = 0; cyc = 0; stalled_once = 1'b0;
    start = 1'b1; in_ready = 1'b0; out_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (in_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) $display("FAIL start_lat m%0d got iv=%b busy=%b done=%b exp 1 1 0", mode, in_valid, busy, done); else n_pass++;
    n_checks++; if (pt_data !== SEED_A || sent_cnt !== 16'd0 || recv_cnt !== 16'd0 || sig !== 128'h0 || ovf_err !== 1'b0) $display("FAIL start_clear m%0d got pt=%h sent=%0d recv=%0d ovf=%b", mode, pt_data, sent_cnt, recv_cnt, ovf_err); else n_pass++;
    while (done !== 1'b1 && cyc < 300) begin
      if (mode == 1 && in_valid === 1'b1 && pt_data === 128'h2 && !stalled_once) begin
        stall_left = 3; stalled_once = 1'b1;
      end
      was_stall = (stall_left > 0);
      if (stall_left > 0) begin
        in_ready = 1'b0; stall_left--;
      end else if (mode == 2) in_ready = ($urandom_range(0, 3) != 0);
      else in_ready = 1'b1;
      if (resp_q.size() > 0 && (mode != 2 || $urandom_range(0, 1) == 1)) begin
        out_valid = 1'b1; ct_data = resp_q.pop_front();
      end else begin
        out_valid = 1'b0; ct_data = rand128();
      end
      start = (mode == 2 && busy === 1'b1) ? 1'($urandom_range(0, 1)) : 1'b0;
      acc = in_valid && in_ready;
      if (acc) begin
        n_checks++; if (pt_data !== exp_pt) $display("FAIL pt_seq m%0d got %h exp %h", mode, pt_data, exp_pt); else n_pass++;
        resp_q.push_back((mode == 2) ? rand128() : pt_data);
        exp_pt = mul_x(exp_pt); msent++;
      end
      if (out_valid && mrecv < NB_A) begin
        msig = msig ^ ct_data; mrecv++;
      end
      @(posedge clk); #1; cyc++;
      if (was_stall) begin
        n_checks++; if (in_valid !== 1'b1 || pt_data !== 128'h2) $display("FAIL stall_hold got iv=%b pt=%h exp iv=1 pt=2", in_valid, pt_data); else n_pass++;
      end
      n_checks++; if (sent_cnt !== 16'(msent) || recv_cnt !== 16'(mrecv)) $display("FAIL counts m%0d got %0d/%0d exp %0d/%0d", mode, sent_cnt, recv_cnt, msent, mrecv); else n_pass++;
      n_checks++; if (sig !== msig) $display("FAIL sig_run m%0d got %h exp %h", mode, sig, msig); else n_pass++;
      n_checks++; if (done !== (mrecv == NB_A) || in_valid !== (msent < NB_A) || busy === done) $display("FAIL ctrl m%0d got done=%b iv=%b busy=%b", mode, done, in_valid, busy); else n_pass++;
    end
    start = 1'b0; out_valid = 1'b0; in_ready = 1'b0;
    n_checks++; if (cyc >= 300) $display("FAIL run_budget m%0d got %0d cycles exp <300", mode, cyc); else n_pass++;
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || sent_cnt !== 16'd4 || recv_cnt !== 16'd4 || ovf_err !== 1'b0) $display("FAIL final m%0d got done=%b sent=%0d recv=%0d ovf=%b", mode, done, sent_cnt, recv_cnt, ovf_err); else n_pass++;
    if (mode != 2) begin
      n_checks++; if (sig !== 128'hF) $display("FAIL final_sig m%0d got %h exp f", mode, sig); else n_pass++;
    end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b1 || sent_cnt !== 16'd4) $display("FAIL done_hold got done=%b sent=%0d", done, sent_cnt); else n_pass++;
  endtask

  task automatic test_ovf();
    out_valid = 1'b1; ct_data = rand128() | 128'h1;
    @(posedge clk); #1;
    out_valid = 1'b0;
    n_checks++; if (ovf_err !== 1'b1 || recv_cnt !== 16'd4) $display("FAIL ovf got ovf=%b recv=%0d exp 1 4", ovf_err, recv_cnt); else n_pass++;
    n_checks++; if (sig !== 128'hF || done !== 1'b1) $display("FAIL ovf_sig got %h done=%b exp f 1", sig, done); else n_pass++;
  endtask

  task automatic test_reset_mid();
    start = 1'b1; in_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (sent_cnt !== 16'd2 || pt_data !== 128'h4) $display("FAIL mid_pre got sent=%0d pt=%h exp 2 4", sent_cnt, pt_data); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++; if (in_valid !== 1'b0 || busy !== 1'b0 || sent_cnt !== 16'd0 || pt_data !== SEED_A || done !== 1'b0) $display("FAIL mid_rst got iv=%b busy=%b sent=%0d pt=%h", in_valid, busy, sent_cnt, pt_data); else n_pass++;
    #1 rst = 1'b0;
    in_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (pt_data !== SEED_A || sent_cnt !== 16'd0 || in_valid !== 1'b1) $display("FAIL mid_restart got pt=%h sent=%0d iv=%b", pt_data, sent_cnt, in_valid); else n_pass++;
    in_ready = 1'b1;
    @(posedge clk); #1;
    in_ready = 1'b0;
    n_checks++; if (sent_cnt !== 16'd1 || pt_data !== 128'h2) $display("FAIL mid_count got sent=%0d pt=%h exp 1 2", sent_cnt, pt_data); else n_pass++;
    #1 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  task automatic test_timeout();
    start = 1'b1; in_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
`ifdef AES_FEED_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 7) begin
        n_checks++; if (timeout_err !== 1'b0 || in_valid !== 1'b1) $display("FAIL to_early got tmo=%b iv=%b exp 0 1", timeout_err, in_valid); else n_pass++;
      end
    end
    n_checks++; if (timeout_err !== 1'b1 || done !== 1'b1 || in_valid !== 1'b0 || busy !== 1'b0) $display("FAIL to_hit got tmo=%b done=%b iv=%b busy=%b", timeout_err, done, in_valid, busy); else n_pass++;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (timeout_err !== 1'b0 || in_valid !== 1'b1) $display("FAIL to_restart got tmo=%b iv=%b exp 0 1", timeout_err, in_valid); else n_pass++;
`else
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
    end
    n_checks++; if (timeout_err !== 1'b0 || in_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || pt_data !== SEED_A) $display("FAIL no_to got tmo=%b iv=%b busy=%b done=%b", timeout_err, in_valid, busy, done); else n_pass++;
`endif
    #1 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wrap();
    test_stream(0);
    test_ovf();
    test_stream(1);
    for (int r = 0; r < 4; r++) test_stream(2);
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/aes_block_feeder.md
Name: aes_block_feeder

Overview:
- Clocked stimulus source that sits directly downstream of the bench clock generator, in the clock domain it produces.
- Emits a deterministic sequence of 128-bit plaintext blocks plus a fixed key to the AES core over a valid/ready handshake.
- Counts the ciphertext responses and XOR-folds them into a signature for end-of-run checking.

Parameters:
- NUM_BLOCKS, 16, number of blocks per run; range 0..65535.
- SEED, 128'h1, initial plaintext (LFSR state) loaded on start.
- KEY, 128'h000102030405060708090a0b0c0d0e0f, key driven on key_data.
- TIMEOUT_CYC, 1024, stall limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  run request, level-sampled on the rising edge.
- pt_data  out  128  plaintext presented to the core.
- key_data  out  128  constant KEY.
- in_valid  out  1  pt_data valid.
- in_ready  in  1  core accepts pt_data.
- out_valid  in  1  core ciphertext valid (single-cycle strobe per block).
- ct_data  in  128  ciphertext.
- busy  out  1  run in progress.
- done  out  1  run complete.
- sent_cnt  out  16  blocks accepted by the core.
- recv_cnt  out  16  ciphertexts received.
- sig  out  128  XOR of all received ct_data.
- ovf_err  out  1  sticky: out_valid seen with recv_cnt == NUM_BLOCKS.
- timeout_err  out  1  sticky stall error.

Behaviour:
- Reset (async, immediate, also mid-run):
  - state=IDLE, lfsr=SEED.
  - in_valid=0, busy=0, done=0, sent_cnt=0, recv_cnt=0, sig=0, ovf_err=0, timeout_err=0.
- key_data = KEY at all times. pt_data = lfsr register at all times.
- LFSR step (GF(2^128) doubling): next = {lfsr[126:0],1'b0} ^ (lfsr[127] ? 128'h87 : 0).
- States: IDLE, SEND, DRAIN, DONE.
- IDLE, start=1:
  - Load lfsr=SEED; clear sent_cnt, recv_cnt, sig, ovf_err.
  - Next state SEND, or DONE if NUM_BLOCKS==0.
- SEND:
  - in_valid=1, busy=1.
  - On in_valid&&in_ready in a cycle: sent_cnt+1, lfsr steps. If sent_cnt+1==NUM_BLOCKS, go to DRAIN with in_valid=0 next cycle; else stay in SEND.
  - While stalled (in_ready=0): in_valid and pt_data hold stable.
  - Back-to-back accepts: one block per cycle.
- DRAIN: in_valid=0, busy=1. When recv_cnt==NUM_BLOCKS (including the update made this cycle), go to DONE.
- DONE:
  - done=1, busy=0, counters and sig hold.
  - start=1 restarts exactly as from IDLE; done drops the next cycle.
- Response capture, in SEND, DRAIN or DONE:
  - out_valid with recv_cnt<NUM_BLOCKS: recv_cnt+1, sig ^= ct_data.
  - out_valid with recv_cnt==NUM_BLOCKS: ovf_err=1, sig unchanged.
  - out_valid in IDLE is ignored.
- Simultaneous accept and out_valid in one cycle: both counted in that cycle.
- start while in SEND or DRAIN: ignored.
- Latency:
  - start→first in_valid: 1 cycle.
  - Last response→done: 1 cycle.
- Counters never wrap: sent_cnt is bounded by NUM_BLOCKS; recv_cnt saturates per the ovf rule.

Optional Feature:
- Macro AES_FEED_TIMEOUT_EN.
- Defined:
  - A 16-bit stall counter increments each cycle in SEND with in_ready=0, or in DRAIN with out_valid=0. It clears on any handshake or response and on leaving those states.
  - When it reaches TIMEOUT_CYC: timeout_err=1 (sticky until reset or restart), next state DONE, in_valid=0.
- Undefined: no stall counter; timeout_err tied 0; the block waits indefinitely.

Test Plan:
- NUM_BLOCKS=4, SEED=1, in_ready=1, ct_data=pt_data looped back 1 cycle later:
  - pt sequence 1,2,4,8.
  - done=1, sent_cnt=recv_cnt=4, sig=128'hF.
- Same setup, in_ready low for 3 cycles on block 2:
  - in_valid stays high and pt_data holds 2 throughout the stall.
  - Final sig=128'hF.
- SEED=128'h8000…0, NUM_BLOCKS=2: second pt=128'h87 (wrap/reduction check).
- Extra out_valid after done with recv_cnt=4: ovf_err=1, recv_cnt stays 4, sig unchanged.
- rst asserted mid-SEND with sent_cnt=2: outputs return to reset values immediately. A new start then gives first pt=SEED and sent_cnt counts from 0.
- With AES_FEED_TIMEOUT_EN and TIMEOUT_CYC=8, in_ready held 0: after 8 stalled cycles timeout_err=1, done=1, in_valid=0.
